// File: rtl/knn_sched.sv
// knn_sched: job sequencer for the K parallel KNN lanes.
//
// A start command clears every lane. The sequencer then fetches N dataset
// words (packed data point + label) from a memory port, one at a time, and
// broadcasts each word to all lanes with a one-cycle enable. It waits for
// every lane to report ready before fetching the next word. A done pulse
// marks the end of the dataset.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      job start pulse, only honoured in IDLE
//   abort      synchronous job cancel, acts in any non-IDLE state
//   base_addr  dataset start address, latched on accepted start
//   n_points   dataset word count, latched on accepted start
//   busy       high whenever a job is in progress
//   done       one-cycle pulse at job completion
//   processed  words broadcast in the current or last job
//   mem_req    memory read request, held until acknowledged
//   mem_addr   read address (base + idx, wrapping)
//   mem_ack    read acknowledge, mem_rdata valid in the same cycle
//   mem_rdata  read data
//   core_clr   one-cycle lane clear
//   core_dp    registered broadcast word shared by all lanes
//   core_en    one-cycle broadcast strobe
//   core_rdy   per-lane ready, a low bit means that lane is still busy
module knn_sched #(
  parameter int K      = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] n_points,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] processed,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_clr,
  output logic [DATA_W-1:0] core_dp,
  output logic              core_en,
  input  logic [K-1:0]      core_rdy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_ISSUE,
    S_WAIT_CORE,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;

  // Exact-width increment: the last-word compare must also work for
  // n_points = 2^ADDR_W-1 without any carry bit.
  assign idx_next = idx + ADDR_W'(1);

  // Single-process FSM. Every output is a register so nothing combinational
  // reaches the ports; the pulse outputs default low each cycle and are
  // raised on the edge that enters the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      n_q       <= '0;
      idx       <= '0;
      processed <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      core_clr  <= 1'b0;
      core_dp   <= '0;
      core_en   <= 1'b0;
    end else begin
      core_clr <= 1'b0;
      core_en  <= 1'b0;
      done     <= 1'b0;
      if (state != S_IDLE && abort) begin
        // Cancel: processed keeps the count of completed words, and a late
        // mem_ack is ignored because FETCH is no longer active.
        state   <= S_IDLE;
        busy    <= 1'b0;
        mem_req <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              base_q    <= base_addr;
              n_q       <= n_points;
              idx       <= '0;
              processed <= '0;
              busy      <= 1'b1;
              core_clr  <= 1'b1;
              state     <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (n_q == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= base_q;
              state    <= S_FETCH;
            end
          end
          S_FETCH: begin
            // Request and address stay put until the ack is sampled.
            if (mem_ack) begin
              core_dp <= mem_rdata;
              mem_req <= 1'b0;
              core_en <= 1'b1;
              state   <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            state <= S_WAIT_CORE;
          end
          S_WAIT_CORE: begin
            // Entered the cycle after core_en, so lanes have seen the word.
            if (&core_rdy) begin
              idx       <= idx_next;
              processed <= idx_next;
              if (idx_next == n_q) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                mem_req  <= 1'b1;
                mem_addr <= base_q + idx_next;
                state    <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_knn_sched.sv
// tb_knn_sched: self-checking bench for knn_sched.
// A memory responder (configurable ack delay, rdata = addr*2) and a lane
// model (lane 2 can hold ready low after each broadcast) surround the DUT.
// A monitor records handshaked addresses and broadcast words; each test
// pushes the expected sequence when it starts a job and compares the
// recorded sequence against it.
module tb_knn_sched;

  localparam int K      = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] n_points = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] processed;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              core_clr;
  logic [DATA_W-1:0] core_dp;
  logic              core_en;
  logic [K-1:0]      core_rdy;

  int checks = 0;
  int failures = 0;

  int mem_delay = 0;
  int lane_stall = 0;
  bit mem_en = 1'b1;
  bit force_ack = 1'b0;

  int en_cnt = 0;
  int done_cnt = 0;
  int clr_cnt = 0;
  int req_cyc = 0;
  int unstable_cnt = 0;
  int early_cnt = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [ADDR_W-1:0] obs_addr[$];
  logic [DATA_W-1:0] exp_dp[$];
  logic [DATA_W-1:0] obs_dp[$];

  knn_sched #(.K(K), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .n_points(n_points),
    .busy(busy), .done(done), .processed(processed),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .core_clr(core_clr), .core_dp(core_dp),
    .core_en(core_en), .core_rdy(core_rdy)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after mem_delay wait cycles with rdata = addr*2.
  // When disabled, it drives force_ack instead so a stray ack can be injected.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!mem_en) begin
        mem_ack = force_ack;
        mem_rdata = 32'hDEAD_BEEF;
        wcnt = 0;
      end else if (mem_req && wcnt >= mem_delay) begin
        mem_ack = 1'b1;
        mem_rdata = {16'h0, mem_addr} << 1;
        wcnt = 0;
      end else if (mem_req) begin
        mem_ack = 1'b0;
        wcnt++;
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Lane model: lane 2 drops ready for lane_stall cycles after each core_en.
  initial begin
    int cnt;
    cnt = 0;
    core_rdy = '1;
    forever begin
      @(posedge clk); #1;
      if (core_en && lane_stall > 0) begin
        core_rdy[2] = 1'b0;
        cnt = lane_stall;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) core_rdy[2] = 1'b1;
      end
    end
  end

  // Monitor: samples mid-cycle and records activity for the tests.
  initial begin
    logic pr, pa;
    logic [ADDR_W-1:0] paddr;
    pr = 1'b0;
    pa = 1'b0;
    paddr = '0;
    forever begin
      @(negedge clk);
      if (mem_req && pr && !pa && mem_addr !== paddr) unstable_cnt++;
      if (mem_req && !(&core_rdy)) early_cnt++;
      if (mem_req) req_cyc++;
      if (mem_req && mem_ack) obs_addr.push_back(mem_addr);
      if (core_en) begin
        en_cnt++;
        obs_dp.push_back(core_dp);
      end
      if (done) done_cnt++;
      if (core_clr) clr_cnt++;
      pr = mem_req;
      pa = mem_ack;
      paddr = mem_addr;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drives a start pulse and pushes the expected address/data sequence.
  task automatic start_job(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    logic [ADDR_W-1:0] a;
    base_addr = b;
    n_points = n;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 16'(i);
      exp_addr.push_back(a);
      exp_dp.push_back({16'h0, a} << 1);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts negedges after the start edge until done is seen; -1 on timeout.
  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_req, core_clr, core_en} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, done, mem_req, core_clr, core_en});
    end
    checks++;
    if (mem_addr !== '0 || core_dp !== '0 || processed !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: got addr=%0h dp=%0h proc=%0h expected 0", mem_addr, core_dp, processed);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic;
    int e0, d0, cyc;
    logic [ADDR_W-1:0] ea, oa;
    logic [DATA_W-1:0] ed, od;
    mem_delay = 0;
    lane_stall = 0;
    @(negedge clk); #1;
    e0 = en_cnt;
    d0 = done_cnt;
    start_job(16'h0010, 16'd3);
    wait_done(100, cyc);
    checks++;
    if (cyc !== 11) begin
      failures++;
      $display("[TB] FAIL basic_done_cycle: got %0d expected 11", cyc);
    end
    @(negedge clk); #1;
    checks++;
    if (en_cnt - e0 !== 3) begin
      failures++;
      $display("[TB] FAIL basic_en_count: got %0d expected 3", en_cnt - e0);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (processed !== 16'd3 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_final: got proc=%0d busy=%b expected 3/0", processed, busy);
    end
    checks++;
    if (obs_addr.size() != exp_addr.size() || obs_dp.size() != exp_dp.size()) begin
      failures++;
      $display("[TB] FAIL basic_seq_len: got %0d/%0d expected %0d/%0d", obs_addr.size(), obs_dp.size(), exp_addr.size(), exp_dp.size());
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      ea = exp_addr.pop_front();
      oa = obs_addr.pop_front();
      checks++;
      if (oa !== ea) begin
        failures++;
        $display("[TB] FAIL basic_addr: got %0h expected %0h", oa, ea);
      end
    end
    while (exp_dp.size() > 0 && obs_dp.size() > 0) begin
      ed = exp_dp.pop_front();
      od = obs_dp.pop_front();
      checks++;
      if (od !== ed) begin
        failures++;
        $display("[TB] FAIL basic_dp: got %0h expected %0h", od, ed);
      end
    end
    exp_addr.delete(); obs_addr.delete(); exp_dp.delete(); obs_dp.delete();
  endtask

  task automatic test_stall;
    int e0, d0, u0, x0, cyc;
    logic [ADDR_W-1:0] ea, oa;
    logic [DATA_W-1:0] ed, od;
    mem_delay = 4;
    lane_stall = 5;
    @(negedge clk); #1;
    e0 = en_cnt; d0 = done_cnt; u0 = unstable_cnt; x0 = early_cnt;
    start_job(16'h0100, 16'd3);
    wait_done(300, cyc);
    // Per word: 5 FETCH + 1 ISSUE + 5 WAIT_CORE cycles.
    checks++;
    if (cyc !== 35) begin
      failures++;
      $display("[TB] FAIL stall_done_cycle: got %0d expected 35", cyc);
    end
    @(negedge clk); #1;
    checks++;
    if (unstable_cnt - u0 !== 0) begin
      failures++;
      $display("[TB] FAIL stall_req_stable: got %0d changes expected 0", unstable_cnt - u0);
    end
    checks++;
    if (early_cnt - x0 !== 0) begin
      failures++;
      $display("[TB] FAIL stall_early_fetch: got %0d expected 0", early_cnt - x0);
    end
    checks++;
    if (en_cnt - e0 !== 3 || done_cnt - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL stall_counts: got en=%0d done=%0d expected 3/1", en_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (processed !== 16'd3) begin
      failures++;
      $display("[TB] FAIL stall_processed: got %0d expected 3", processed);
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      ea = exp_addr.pop_front();
      oa = obs_addr.pop_front();
      checks++;
      if (oa !== ea) begin
        failures++;
        $display("[TB] FAIL stall_addr: got %0h expected %0h", oa, ea);
      end
    end
    while (exp_dp.size() > 0 && obs_dp.size() > 0) begin
      ed = exp_dp.pop_front();
      od = obs_dp.pop_front();
      checks++;
      if (od !== ed) begin
        failures++;
        $display("[TB] FAIL stall_dp: got %0h expected %0h", od, ed);
      end
    end
    exp_addr.delete(); obs_addr.delete(); exp_dp.delete(); obs_dp.delete();
    mem_delay = 0;
    lane_stall = 0;
  endtask

  task automatic test_empty;
    int e0, d0, c0, r0;
    @(negedge clk); #1;
    e0 = en_cnt; d0 = done_cnt; c0 = clr_cnt; r0 = req_cyc;
    start_job(16'h0030, 16'd0);
    @(negedge clk);
    checks++;
    if (core_clr !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL empty_clear: got clr=%b req=%b expected 1/0", core_clr, mem_req);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || core_clr !== 1'b0) begin
      failures++;
      $display("[TB] FAIL empty_done: got done=%b clr=%b expected 1/0", done, core_clr);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || processed !== '0) begin
      failures++;
      $display("[TB] FAIL empty_final: got busy=%b proc=%0d expected 0/0", busy, processed);
    end
    checks++;
    if (en_cnt - e0 !== 0 || req_cyc - r0 !== 0 || clr_cnt - c0 !== 1 || done_cnt - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL empty_counts: got en=%0d req=%0d clr=%0d done=%0d expected 0/0/1/1",
               en_cnt - e0, req_cyc - r0, clr_cnt - c0, done_cnt - d0);
    end
  endtask

  task automatic test_abort;
    int e0, d0, rises;
    logic prev;
    logic [DATA_W-1:0] ed, od;
    mem_delay = 2;
    lane_stall = 0;
    @(negedge clk); #1;
    e0 = en_cnt; d0 = done_cnt;
    start_job(16'h0040, 16'd5);
    rises = 0;
    prev = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mem_req && !prev) rises++;
      prev = mem_req;
      if (rises == 3) break;
    end
    checks++;
    if (rises !== 3) begin
      failures++;
      $display("[TB] FAIL abort_third_fetch: got %0d fetches expected 3", rises);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    mem_en = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || core_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle: got busy=%b req=%b en=%b expected 0/0/0", busy, mem_req, core_en);
    end
    checks++;
    if (processed !== 16'd2) begin
      failures++;
      $display("[TB] FAIL abort_processed: got %0d expected 2", processed);
    end
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (en_cnt - e0 !== 2 || done_cnt - d0 !== 0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_late_ack: got en=%0d done=%0d busy=%b expected 2/0/0", en_cnt - e0, done_cnt - d0, busy);
    end
    checks++;
    if (core_dp !== 32'h0000_0082) begin
      failures++;
      $display("[TB] FAIL abort_dp_hold: got %0h expected 82", core_dp);
    end
    checks++;
    if (obs_dp.size() != 2) begin
      failures++;
      $display("[TB] FAIL abort_word_count: got %0d expected 2", obs_dp.size());
    end
    while (obs_dp.size() > 0 && exp_dp.size() > 0) begin
      ed = exp_dp.pop_front();
      od = obs_dp.pop_front();
      checks++;
      if (od !== ed) begin
        failures++;
        $display("[TB] FAIL abort_dp: got %0h expected %0h", od, ed);
      end
    end
    exp_addr.delete(); obs_addr.delete(); exp_dp.delete(); obs_dp.delete();
    mem_en = 1'b1;
    mem_delay = 0;
  endtask

  task automatic test_wrap;
    int e0, d0, cyc;
    logic [ADDR_W-1:0] ea, oa;
    logic [DATA_W-1:0] ed, od;
    mem_delay = 0;
    lane_stall = 0;
    @(negedge clk); #1;
    e0 = en_cnt; d0 = done_cnt;
    start_job(16'hFFFE, 16'd4);
    repeat (3) @(negedge clk);
    base_addr = 16'h1234;
    n_points = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, cyc);
    checks++;
    if (cyc + 4 !== 14) begin
      failures++;
      $display("[TB] FAIL wrap_done_cycle: got %0d expected 14", cyc + 4);
    end
    @(negedge clk); #1;
    checks++;
    if (processed !== 16'd4 || en_cnt - e0 !== 4 || done_cnt - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL wrap_counts: got proc=%0d en=%0d done=%0d expected 4/4/1", processed, en_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (obs_addr.size() != 4) begin
      failures++;
      $display("[TB] FAIL wrap_addr_count: got %0d expected 4", obs_addr.size());
    end
    while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
      ea = exp_addr.pop_front();
      oa = obs_addr.pop_front();
      checks++;
      if (oa !== ea) begin
        failures++;
        $display("[TB] FAIL wrap_addr: got %0h expected %0h", oa, ea);
      end
    end
    while (exp_dp.size() > 0 && obs_dp.size() > 0) begin
      ed = exp_dp.pop_front();
      od = obs_dp.pop_front();
      checks++;
      if (od !== ed) begin
        failures++;
        $display("[TB] FAIL wrap_dp: got %0h expected %0h", od, ed);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_second_start: got busy=%b req=%b expected 0/0", busy, mem_req);
    end
    exp_addr.delete(); obs_addr.delete(); exp_dp.delete(); obs_dp.delete();
  endtask

  task automatic test_reset_mid;
    int ens;
    mem_delay = 0;
    lane_stall = 5;
    @(negedge clk); #1;
    start_job(16'h0200, 16'd4);
    ens = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (core_en) ens++;
      if (ens == 2) break;
    end
    checks++;
    if (ens !== 2) begin
      failures++;
      $display("[TB] FAIL rstmid_reach_wait: got %0d broadcasts expected 2", ens);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || processed !== 16'd1) begin
      failures++;
      $display("[TB] FAIL rstmid_pre: got busy=%b proc=%0d expected 1/1", busy, processed);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_req, core_clr, core_en} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_ctrl: got %b expected 00000", {busy, done, mem_req, core_clr, core_en});
    end
    checks++;
    if (processed !== '0 || core_dp !== '0 || mem_addr !== '0) begin
      failures++;
      $display("[TB] FAIL rstmid_data: got proc=%0h dp=%0h addr=%0h expected 0", processed, core_dp, mem_addr);
    end
    lane_stall = 0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_idle: got busy=%b req=%b expected 0/0", busy, mem_req);
    end
    exp_addr.delete(); obs_addr.delete(); exp_dp.delete(); obs_dp.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_abort();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
